// File: rtl/nor_sniff_pkg.sv
// Shared definitions for the NOR bus sniffer: record kinds, header layout
// and the record length helper used to size the serializer and FIFO.
package nor_sniff_pkg;

    typedef enum logic [1:0] {
        KIND_ADDR = 2'b00,
        KIND_RD   = 2'b01,
        KIND_WR   = 2'b10
    } kind_e;

    localparam int HDR_KIND_HI = 7;
    localparam int HDR_KIND_LO = 6;
    localparam int HDR_LOST    = 5;

    // Header + zero-padded address bytes (+ data bytes in bus-cycle mode).
    function automatic int rec_bytes(input int addr_w, input int data_w, input int mode);
        return 1 + (addr_w + 7) / 8 + ((mode != 0) ? (data_w + 7) / 8 : 0);
    endfunction

endpackage

// File: rtl/nor_bus_sniffer_if.sv
// Sniffed NOR bus plus the outgoing byte stream; master is the bus/sink side,
// slave is the sniffer.
interface nor_bus_sniffer_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] nor_a;
    logic [DATA_W-1:0] nor_d;
    logic              nor_ce_n;
    logic              nor_oe_n;
    logic              nor_we_n;
    logic              tx_space;
    logic [7:0]        tx_data;
    logic              tx_wr;

    modport master (
        output nor_a, nor_d, nor_ce_n, nor_oe_n, nor_we_n, tx_space,
        input  tx_data, tx_wr
    );

    modport slave (
        input  nor_a, nor_d, nor_ce_n, nor_oe_n, nor_we_n, tx_space,
        output tx_data, tx_wr
    );
endinterface

// File: rtl/sniff_fifo.sv
// Record FIFO on an inferred RAM with registered read; one slot is kept free so
// full/empty come straight from the pointers.
module sniff_fifo #(
    parameter int WIDTH = 32,
    parameter int LOG   = 13
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid
);
    logic [WIDTH-1:0] mem [2**LOG];
    logic [LOG-1:0]   wr_ptr, rd_ptr, rd_addr;

    assign full    = (wr_ptr + LOG'(1)) == rd_ptr;
    // Read ahead of the pop so the next head is registered without a bubble.
    assign rd_addr = rd_pop ? rd_ptr + LOG'(1) : rd_ptr;

    always_ff @(posedge mclk) begin
        if (wr_en && !full) mem[wr_ptr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    // A slot equal to the pre-write wr_ptr is not yet readable this cycle.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_en && !full) wr_ptr <= wr_ptr + LOG'(1);
            rd_ptr   <= rd_addr;
            rd_valid <= rd_addr != wr_ptr;
        end
    end
endmodule

// File: rtl/nor_bus_sniffer.sv
// NOR flash bus sniffer: captures address changes (MODE 0) or completed bus
// cycles (MODE 1) into a record FIFO and streams them byte-wise to a paced sink.
module nor_bus_sniffer
    import nor_sniff_pkg::*;
#(
    parameter int ADDR_W        = 23,
    parameter int DATA_W        = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int FIFO_LOG      = 13,
    parameter int MODE          = 0
) (
    input  logic             mclk,
    input  logic             reset,
    nor_bus_sniffer_if.slave bus,
    input  logic             enable,
    output logic             overflow,
    output logic [15:0]      lost_count,
    output logic             event_tog
);
    localparam int NB    = rec_bytes(ADDR_W, DATA_W, MODE);
    localparam int AB    = (ADDR_W + 7) / 8;
    localparam int DB    = (DATA_W + 7) / 8;
    localparam int FW    = (1 + AB + DB) * 8;
    localparam int IDX_W = $clog2(NB);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    logic [SYNC_STAGES-1:0][ADDR_W-1:0] a_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] d_sync;
    logic [SYNC_STAGES-1:0][2:0]        s_sync;   // {ce_n, oe_n, we_n}

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            a_sync <= '0;
            d_sync <= '0;
            s_sync <= '1;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], bus.nor_a};
            d_sync <= {d_sync[SYNC_STAGES-2:0], bus.nor_d};
            s_sync <= {s_sync[SYNC_STAGES-2:0], {bus.nor_ce_n, bus.nor_oe_n, bus.nor_we_n}};
        end
    end

    logic [ADDR_W-1:0] a_s, a_q, last_addr, cand;
    logic [DATA_W-1:0] d_q;
    logic              oe_s, we_s, ce_q, oe_q, we_q;
    logic [CNT_W-1:0]  stab_cnt, new_cnt;
    logic              cap, accept, drop, fifo_full, lost_flag;
    kind_e             cap_kind;
    logic [ADDR_W-1:0] cap_a;

    assign a_s  = a_sync[SYNC_STAGES-1];
    assign oe_s = s_sync[SYNC_STAGES-1][1];
    assign we_s = s_sync[SYNC_STAGES-1][0];

    always_comb begin
        cap      = 1'b0;
        cap_kind = KIND_ADDR;
        cap_a    = a_s;
        new_cnt  = CNT_W'(1);
        if (cand == a_s && stab_cnt != '0) new_cnt = stab_cnt + CNT_W'(1);
        if (MODE == 0) begin
            cap = (a_s != last_addr) && (new_cnt == CNT_W'(STABLE_CYCLES));
        end else begin
            cap_a = a_q;
            // A write edge wins when both strobes rise together.
            if (!ce_q && we_s && !we_q) begin
                cap      = 1'b1;
                cap_kind = KIND_WR;
            end else if (!ce_q && oe_s && !oe_q) begin
                cap      = 1'b1;
                cap_kind = KIND_RD;
            end
        end
    end

    // Detection state tracks regardless of enable so re-enabling is glitch-free.
    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            last_addr <= '0;
            cand      <= '0;
            stab_cnt  <= '0;
            a_q       <= '0;
            d_q       <= '0;
            ce_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
        end else begin
            a_q  <= a_s;
            d_q  <= d_sync[SYNC_STAGES-1];
            ce_q <= s_sync[SYNC_STAGES-1][2];
            oe_q <= oe_s;
            we_q <= we_s;
            if (a_s == last_addr) begin
                stab_cnt <= '0;
            end else if (new_cnt == CNT_W'(STABLE_CYCLES)) begin
                stab_cnt  <= '0;
                last_addr <= a_s;
            end else begin
                stab_cnt <= new_cnt;
                cand     <= a_s;
            end
        end
    end

    logic [7:0]        hdr;
    logic [AB*8-1:0]   a_pad;
    logic [DB*8-1:0]   d_pad;
    logic [FW-1:0]     full_img;
    logic [NB*8-1:0]   img, rd_img;

    always_comb begin
        hdr                          = '0;
        hdr[HDR_KIND_HI:HDR_KIND_LO] = cap_kind;
        hdr[HDR_LOST]                = lost_flag;
        a_pad                        = '0;
        a_pad[ADDR_W-1:0]            = cap_a;
        d_pad                        = '0;
        d_pad[DATA_W-1:0]            = d_q;
        full_img                     = {hdr, a_pad, d_pad};
    end
    // MODE 0 records stop after the address, dropping the data bytes.
    assign img = full_img[FW-1 -: NB*8];

    logic unused_sink;
    assign unused_sink = ^{full_img, ce_q, oe_q, we_q, a_q};

    assign accept = cap && enable && !fifo_full;
    assign drop   = cap && enable && fifo_full;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            overflow   <= 1'b0;
            lost_count <= '0;
            lost_flag  <= 1'b0;
            event_tog  <= 1'b0;
        end else if (accept) begin
            lost_flag <= 1'b0;
            event_tog <= ~event_tog;
        end else if (drop) begin
            overflow  <= 1'b1;
            lost_flag <= 1'b1;
            if (lost_count != 16'hFFFF) lost_count <= lost_count + 16'd1;
        end
    end

    logic                 rd_valid, pop, send;
    logic [IDX_W-1:0]     byte_idx, sel;
    logic [NB-1:0][7:0]   rd_bytes;
    logic [7:0]           tx_data_q;
    logic                 tx_wr_q;

    sniff_fifo #(
        .WIDTH (NB * 8),
        .LOG   (FIFO_LOG)
    ) u_fifo (
        .mclk     (mclk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_data  (img),
        .full     (fifo_full),
        .rd_pop   (pop),
        .rd_data  (rd_img),
        .rd_valid (rd_valid)
    );

    assign rd_bytes = rd_img;
    assign sel      = IDX_W'(NB - 1) - byte_idx;
    assign send     = rd_valid && bus.tx_space;
    assign pop      = send && (byte_idx == IDX_W'(NB - 1));

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            byte_idx  <= '0;
            tx_wr_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            tx_wr_q <= send;
            if (send) begin
                tx_data_q <= rd_bytes[sel];
                byte_idx  <= pop ? '0 : byte_idx + IDX_W'(1);
            end
        end
    end

    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;
endmodule
